adder_result_tx: RTL



---
 rtl/adder_tx_pkg.sv | 24 ++
 rtl/adder_tx_baud.sv | 29 ++
 rtl/adder_result_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/adder_tx_pkg.sv
// adder_tx_pkg: shared types and constants for the adder result serial transmitter.
//   tx_state_t : frame sequencer states (PARITY always present in the encoding)
//   DATA_BITS  : payload bits per frame
//   FRAME_BITS : bit periods per frame (10, or 11 when ADDER_TX_PARITY_EN is defined)
// Optional feature macro: ADDER_TX_PARITY_EN
package adder_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

`ifdef ADDER_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/adder_tx_baud.sv
// adder_tx_baud: bit-period timer for the serial transmitter.
//   clk      in  : clock, rising edge
//   rst_n    in  : synchronous active-low reset
//   clear    in  : hold/restart the count at 0
//   bit_done out : one-cycle pulse on the last cycle of a bit period
module adder_tx_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == LAST);

  // The count restarts on its own at the bit boundary, so it never wraps
  // through the unused codes when CLKS_PER_BIT is not a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || bit_done) cnt <= '0;
    else                             cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/adder_result_tx.sv
// adder_result_tx: sends one 8-bit adder result per valid/ready handshake as an
// asynchronous serial frame (start, 8 data bits LSB first, [even parity], stop).
//   clk       in  : clock, rising edge
//   rst_n     in  : synchronous active-low reset, aborts any frame in flight
//   data_in   in  : result word, captured on acceptance
//   valid_in  in  : data_in valid
//   ready_out out : idle, a word can be accepted
//   tx_out    out : serial line (registered), idles high
//   busy_out  out : frame in progress
// Optional feature macro: ADDER_TX_PARITY_EN (adds the even-parity bit period)
module adder_result_tx
  import adder_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic              busy_out
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t         state, next_state;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic              bit_done;
  logic              baud_clear;
  logic              accept;
`ifdef ADDER_TX_PARITY_EN
  logic              par_q;
`endif

  adder_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  assign ready_out = (state == IDLE);
  assign busy_out  = !ready_out;
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    baud_clear = 1'b0;
    case (state)
      IDLE: begin
        // Timer held at zero while idle, so acceptance starts a full period.
        baud_clear = 1'b1;
        if (accept) next_state = START;
      end
      START: if (bit_done) next_state = DATA;
      DATA: begin
        if (bit_done && bit_idx == LAST_BIT) begin
`ifdef ADDER_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef ADDER_TX_PARITY_EN
      PARITY: if (bit_done) next_state = STOP;
`endif
      STOP: if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line register loads the value of the bit period that begins at this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_out  <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef ADDER_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_out  <= 1'b1;
          bit_idx <= '0;
          if (accept) begin
            shreg  <= data_in;
            tx_out <= 1'b0;
`ifdef ADDER_TX_PARITY_EN
            par_q  <= ^data_in;
`endif
          end
        end
        START: if (bit_done) tx_out <= shreg[0];
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
`ifdef ADDER_TX_PARITY_EN
              tx_out <= par_q;
`else
              tx_out <= 1'b1;
`endif
            end else begin
              shreg   <= shreg >> 1;
              tx_out  <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: if (bit_done) tx_out <= 1'b1;
      endcase
    end
  end

endmodule
